// File: rtl/lamp_pkg.sv
// Shared constants, state encoding and checksum helper for the LED frame ingest path.
// The default geometry is 30 LED boards of 32 channels at 12 bits per channel.
package lamp_pkg;

    localparam int c_ledboards   = 30;
    localparam int c_bpc         = 12;
    localparam int c_channels    = c_ledboards * 32;
    localparam int c_addr_w      = $clog2(c_channels);
    localparam int c_frame_bytes = c_channels * 3 / 2;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_RECV = 2'd2
    } state_t;

    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/frame_loader_spi_rx_sync.sv
// Two-flop synchronisers for the SPI pins, plus a third stage on sck/csn for edge detection.
// Reset levels are the idle bus: sck=0, mosi=0, csn=1.
module spi_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic mosi,
    input  logic csn,
    output logic sck_rise,
    output logic csn_fall,
    output logic csn_rise,
    output logic mosi_s,
    output logic csn_s
);

    logic [2:0] sck_r;
    logic [1:0] mosi_r;
    logic [2:0] csn_r;

    // Shift each pin through its synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_r  <= 3'b000;
            mosi_r <= 2'b00;
            csn_r  <= 3'b111;
        end else begin
            sck_r  <= {sck_r[1:0], sck};
            mosi_r <= {mosi_r[0], mosi};
            csn_r  <= {csn_r[1:0], csn};
        end
    end

    assign sck_rise = sck_r[1] & ~sck_r[2];
    assign csn_fall = ~csn_r[1] & csn_r[2];
    assign csn_rise = csn_r[1] & ~csn_r[2];
    assign mosi_s   = mosi_r[1];
    assign csn_s    = csn_r[1];

endmodule

// File: rtl/frame_loader.sv
// SPI-slave frame ingest: unpacks 3 bytes into 2 x 12-bit channels and drives the framebuffer write port.
// Build option FRAME_LOADER_CHECKSUM_EN adds a trailing XOR byte that must match for a frame to be accepted.
module frame_loader #(
    parameter  int c_ledboards = lamp_pkg::c_ledboards,
    parameter  int c_bpc       = lamp_pkg::c_bpc,
    localparam int c_channels  = c_ledboards * 32,
    localparam int c_addr_w    = $clog2(c_channels)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_sck,
    input  logic                i_mosi,
    input  logic                i_csn,
    output logic                o_wen,
    output logic [c_addr_w-1:0] o_waddr,
    output logic [c_bpc-1:0]    o_wdata,
    output logic                o_frame_done,
    output logic                o_frame_err
);

    import lamp_pkg::*;

    localparam int c_frame_bytes = c_channels * 3 / 2;
`ifdef FRAME_LOADER_CHECKSUM_EN
    localparam int c_total_bytes = c_frame_bytes + 1;
`else
    localparam int c_total_bytes = c_frame_bytes;
`endif
    localparam int                   c_cnt_w     = $clog2(c_total_bytes + 1) + 1;
    localparam logic [c_cnt_w-1:0]   c_cnt_max   = {c_cnt_w{1'b1}};
    localparam logic [c_cnt_w-1:0]   c_total_cnt = c_cnt_w'(c_total_bytes);
    localparam logic [c_addr_w-1:0]  c_last_addr = c_addr_w'(c_channels - 1);

    generate
        if (c_bpc != 12) begin : g_bpc_check
            $error("frame_loader: only c_bpc == 12 is supported");
        end
    endgenerate

    logic               sck_rise_s, csn_fall_s, csn_rise_s, mosi_s, csn_s;
    state_t             state_r, state_nx_s;
    logic [1:0]         settle_r;
    logic [6:0]         shift_r;
    logic [2:0]         bit_cnt_r, bit_cnt_nx_s;
    logic [c_cnt_w-1:0] byte_cnt_r, byte_cnt_nx_s;
    logic [1:0]         phase_r;
    logic [7:0]         b0_r;
    logic [3:0]         b1lo_r;
    logic [c_addr_w-1:0] addr_r;
    logic               full_r;
    logic [7:0]         byte_s;
    logic               byte_done_s, wr_req_s, sum_ok_s, frame_ok_s;
    logic [c_bpc-1:0]   wr_data_s;
    logic               wen_r, done_r, err_r;
    logic [c_addr_w-1:0] waddr_r;
    logic [c_bpc-1:0]   wdata_r;

    spi_rx_sync u_sync (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .sck      (i_sck),
        .mosi     (i_mosi),
        .csn      (i_csn),
        .sck_rise (sck_rise_s),
        .csn_fall (csn_fall_s),
        .csn_rise (csn_rise_s),
        .mosi_s   (mosi_s),
        .csn_s    (csn_s)
    );

    // settle_r lets the synchronisers flush their reset value before csn is trusted,
    // so a frame still in progress across reset is not mistaken for an idle bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_SYNC;
            settle_r <= 2'd0;
        end else begin
            state_r  <= state_nx_s;
            settle_r <= (settle_r == 2'd3) ? settle_r : settle_r + 2'd1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_SYNC: begin
                if (settle_r == 2'd3 && csn_s) state_nx_s = ST_IDLE;
                else                           state_nx_s = ST_SYNC;
            end
            ST_IDLE: begin
                if (csn_fall_s) state_nx_s = ST_RECV;
                else            state_nx_s = ST_IDLE;
            end
            ST_RECV: begin
                if (csn_rise_s) state_nx_s = ST_IDLE;
                else            state_nx_s = ST_RECV;
            end
            default: state_nx_s = ST_SYNC;
        endcase
    end

    // Decode this cycle's sck edge into bit, byte and channel-write events
    always_comb begin
        byte_s        = {shift_r, mosi_s};
        byte_done_s   = 1'b0;
        bit_cnt_nx_s  = bit_cnt_r;
        byte_cnt_nx_s = byte_cnt_r;
        wr_req_s      = 1'b0;
        wr_data_s     = 12'h000;
        if (state_r == ST_RECV && sck_rise_s) begin
            bit_cnt_nx_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
                byte_done_s = 1'b1;
                if (byte_cnt_r == c_cnt_max) byte_cnt_nx_s = byte_cnt_r;
                else                         byte_cnt_nx_s = byte_cnt_r + c_cnt_w'(1);
                case (phase_r)
                    2'd1: begin
                        wr_req_s  = 1'b1;
                        wr_data_s = {b0_r, byte_s[7:4]};
                    end
                    2'd2: begin
                        wr_req_s  = 1'b1;
                        wr_data_s = {b1lo_r, byte_s};
                    end
                    default: begin
                        wr_req_s  = 1'b0;
                        wr_data_s = 12'h000;
                    end
                endcase
            end else begin
                byte_done_s = 1'b0;
            end
        end else begin
            bit_cnt_nx_s = bit_cnt_r;
        end
    end

`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [7:0] sum_r, sum_nx_s;

    assign sum_nx_s = byte_done_s ? xor_fold(sum_r, byte_s) : sum_r;
    assign sum_ok_s = (sum_nx_s == 8'h00);

    // Running XOR over every byte including the trailer; a good frame folds to zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_r <= 8'h00;
        end else if (state_r == ST_IDLE && csn_fall_s) begin
            sum_r <= 8'h00;
        end else if (state_r == ST_RECV) begin
            sum_r <= sum_nx_s;
        end
    end
`else
    assign sum_ok_s = 1'b1;
`endif

    // Verdict uses the next-counter values so a byte finishing with the csn rise still counts
    assign frame_ok_s = (byte_cnt_nx_s == c_total_cnt) && (bit_cnt_nx_s == 3'd0) && sum_ok_s;

    // Frame counters, unpacking registers and registered write/status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_r    <= 7'd0;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= {c_cnt_w{1'b0}};
            phase_r    <= 2'd0;
            b0_r       <= 8'h00;
            b1lo_r     <= 4'h0;
            addr_r     <= {c_addr_w{1'b0}};
            full_r     <= 1'b0;
            wen_r      <= 1'b0;
            waddr_r    <= {c_addr_w{1'b0}};
            wdata_r    <= 12'h000;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            wen_r  <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (state_r == ST_IDLE && csn_fall_s) begin
                shift_r    <= 7'd0;
                bit_cnt_r  <= 3'd0;
                byte_cnt_r <= {c_cnt_w{1'b0}};
                phase_r    <= 2'd0;
                addr_r     <= {c_addr_w{1'b0}};
                full_r     <= 1'b0;
            end else if (state_r == ST_RECV) begin
                bit_cnt_r  <= bit_cnt_nx_s;
                byte_cnt_r <= byte_cnt_nx_s;
                if (sck_rise_s) shift_r <= byte_s[6:0];
                if (byte_done_s) begin
                    case (phase_r)
                        2'd0:    begin b0_r <= byte_s;        phase_r <= 2'd1; end
                        2'd1:    begin b1lo_r <= byte_s[3:0]; phase_r <= 2'd2; end
                        default: phase_r <= 2'd0;
                    endcase
                end
                if (wr_req_s && !full_r) begin
                    wen_r   <= 1'b1;
                    waddr_r <= addr_r;
                    wdata_r <= wr_data_s;
                    if (addr_r == c_last_addr) full_r <= 1'b1;
                    else                       addr_r <= addr_r + c_addr_w'(1);
                end
                if (csn_rise_s) begin
                    done_r <= frame_ok_s;
                    err_r  <= ~frame_ok_s;
                end
            end
        end
    end

    assign o_wen        = wen_r;
    assign o_waddr      = waddr_r;
    assign o_wdata      = wdata_r;
    assign o_frame_done = done_r;
    assign o_frame_err  = err_r;

endmodule
